div_control: RTL
================

Name: div_control

Overview:
- Control FSM for the N-bit restoring divider datapath (regAQ/regM/ula/counter).
- Sits directly upstream of the datapath and drives its strobes: load, shift, hab_A, set_Q0, op.
- Consumes the datapath's remainder sign bit (regA[N]).
- Provides a start/busy/done handshake to the system, so a division runs from one start pulse to one done pulse.

Parameters:
- N, 4, operand width in bits. Must match the datapath N; N >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- a_sign  input  1  datapath regA[N]; 1 = partial remainder negative.
- divisor  input  N  datapath divisor operand; used only by the optional feature.
- load  output  1  datapath load of A=0, Q=dividend, M=divisor.
- shift  output  1  datapath left shift of A:Q.
- hab_A  output  1  datapath write-enable of A from the ULA result.
- set_Q0  output  1  datapath set of Q[0]=1.
- op  output  1  ULA select: 1 = A-M, 0 = A+M.
- busy  output  1  high from LOAD through the last iteration.
- done  output  1  one-cycle pulse: quotient/remainder valid in regQ/regA.
- err  output  1  divide-by-zero flag (see Optional Feature).
- iter  output  $clog2(N+1)  completed-iteration count, 0..N.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, iter = 0.
  - All strobes, busy, done and err = 0.
  - Applies immediately, including mid-division; the datapath contents are then don't-care.
- States: IDLE, LOAD, SHIFT, SUB, TEST, DONE (binary encoded).
- Decoding: all outputs are decoded from state, except hab_A/op/set_Q0 in TEST, which also depend on a_sign. Every strobe not listed for a state is 0.
- IDLE:
  - busy=0.
  - start=1 at an edge -> LOAD.
  - Otherwise stay in IDLE.
- LOAD: load=1, busy=1; iter<=0; next state SHIFT.
- SHIFT: shift=1, busy=1; next state SUB.
- SUB: hab_A=1, op=1 (A<=A-M), busy=1; next state TEST.
- TEST: busy=1; a_sign reflects the subtraction.
  - a_sign=0: set_Q0=1, A is kept.
  - a_sign=1: hab_A=1, op=0 (restore A<=A+M); Q[0] stays 0 from the shift.
  - iter<=iter+1.
  - If iter==N-1 -> DONE, else -> SHIFT.
- DONE:
  - done=1 and busy=0, for exactly one cycle; next state IDLE.
  - regQ = quotient, regA[N-1:0] = remainder, regA[N]=0. Results are held until the next LOAD.
- Latency:
  - Accepting edge -> LOAD (1 cycle) -> 3N iteration cycles -> DONE.
  - done is high in the cycle following edge 3N+1 after the accepting edge; N=4 -> edge 13.
  - Throughput: one division per 3N+3 cycles (start may be held high continuously).
- start outside IDLE is ignored; no queuing.
- start held high through DONE:
  - Re-accepted in IDLE, one cycle after the done pulse.
  - done is never asserted on the same cycle as load.
- iter saturates at N. It is cleared only in LOAD and on reset, and is independent of the datapath counter.

Optional Feature:
- Macro: DIV_ZERO_DET_EN.
- Defined:
  - In IDLE, start=1 with divisor==0 goes directly to DONE.
  - No load, shift or hab_A is issued.
  - err=1 together with done for that one cycle.
  - regQ/regA are left unchanged.
  - err is 0 in every other cycle.
- Not defined:
  - divisor is ignored and err is tied to 0.
  - Division by zero runs normally and yields Q = all ones, R = dividend.

Test Plan (N=4, controller instantiated with the division datapath):
- Reset, dividend=13, divisor=4, start pulse -> done at edge 13, regQ=3, regA=1, busy high edges 1-12, exactly 4 shift pulses, iter=4.
- 7/7 -> regQ=1, regA=0; 15/1 -> regQ=15, regA=0; 0/5 -> regQ=0, regA=0; each done exactly once.
- start re-pulsed at edges 3, 6 and 9 of a 9/2 division -> ignored; single done at edge 13; regQ=4, regA=1.
- rst=0 asserted during SUB of iteration 2 -> all outputs 0 immediately; after release, a new 6/4 division -> regQ=1, regA=2.
- start held high for 40 cycles -> back-to-back divisions, done every 15 cycles, no cycle with both load and done.
- DIV_ZERO_DET_EN defined, divisor=0, start -> done and err high at edge 1, no load/shift; undefined -> normal run, regQ=15, err=0.

Source files
------------

// File: rtl/div_control.sv
// rtl/div_control.sv - control FSM for the N-bit restoring divider datapath
//
// Sequences one restoring division per start pulse.
// The sequence is LOAD, then N x (SHIFT, SUB, TEST), then a one-cycle DONE.
//
// Optional build macro: DIV_ZERO_DET_EN
//   - Defined: start with divisor==0 goes straight to DONE with err=1.
//   - Undefined: divisor is ignored and err stays 0.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   division request, sampled only in IDLE
//   a_sign   in   datapath regA[N], 1 = partial remainder negative
//   divisor  in   datapath divisor operand (zero detection only)
//   load     out  datapath load: A=0, Q=dividend, M=divisor
//   shift    out  datapath left shift of A:Q
//   hab_A    out  datapath write-enable of A from the ULA
//   set_Q0   out  datapath set of Q[0]
//   op       out  ULA select, 1 = A-M, 0 = A+M
//   busy     out  high from LOAD through the last TEST
//   done     out  one-cycle pulse, results valid in regQ/regA
//   err      out  divide-by-zero flag, qualifies done
//   iter     out  completed-iteration count, 0..N

module div_control #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     a_sign,
    input  logic [N-1:0]             divisor,
    output logic                     load,
    output logic                     shift,
    output logic                     hab_A,
    output logic                     set_Q0,
    output logic                     op,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(N+1)-1:0]   iter
);

    localparam int IW = $clog2(N+1);
    localparam logic [IW-1:0] ITER_LAST = IW'(N - 1);
    localparam logic [IW-1:0] ITER_MAX  = IW'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_TEST  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;

    // Registered state flags for SUB and TEST.
    // They are used to build the a_sign-dependent strobes.
    logic sub_q;
    logic test_q;
    logic div_zero;

`ifdef DIV_ZERO_DET_EN
    assign div_zero = (divisor == '0);
`else
    logic unused_divisor;
    assign unused_divisor = ^divisor;
    assign div_zero       = 1'b0;
`endif

    // Each registered output is set on the edge that enters the state owning it.
    // As a result, every output is a clean function of the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            iter   <= '0;
            load   <= 1'b0;
            shift  <= 1'b0;
            sub_q  <= 1'b0;
            test_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            load   <= 1'b0;
            shift  <= 1'b0;
            sub_q  <= 1'b0;
            test_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            // Skip the datapath entirely.
                            // Results from the previous division stay in place.
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            load  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    iter  <= '0;
                    state <= S_SHIFT;
                    shift <= 1'b1;
                    busy  <= 1'b1;
                end
                S_SHIFT: begin
                    state <= S_SUB;
                    sub_q <= 1'b1;
                    busy  <= 1'b1;
                end
                S_SUB: begin
                    state  <= S_TEST;
                    test_q <= 1'b1;
                    busy   <= 1'b1;
                end
                S_TEST: begin
                    if (iter != ITER_MAX) begin
                        iter <= iter + 1'b1;
                    end
                    if (iter == ITER_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                        shift <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // In TEST, a_sign only becomes valid after the subtraction.
    // The restore/keep decision therefore stays combinational on it.
    assign hab_A  = sub_q | (test_q & a_sign);
    assign op     = sub_q;
    assign set_Q0 = test_q & ~a_sign;

endmodule
